// File: rtl/sp_port_arbiter.sv
// Request/grant arbiter that lets N masters share one single-port BSRAM, with
// round-robin or fixed-select ownership, optional hold limit and tagged read return.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no owner; BSRAM ce low; picks a winner that owns from next cycle
//   S_OWNED | m_gnt[owner] high; BSRAM pins follow the owner's signals
module sp_port_arbiter #(
  parameter int N_MASTERS    = 3,
  parameter int AD_WIDTH     = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MODE         = 1,
  parameter int MAX_HOLD     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(N_MASTERS)-1:0]     sel,
  input  logic [N_MASTERS-1:0]             m_req,
  output logic [N_MASTERS-1:0]             m_gnt,
  input  logic [N_MASTERS-1:0]             m_ce,
  input  logic [N_MASTERS-1:0]             m_wre,
  input  logic [N_MASTERS*AD_WIDTH-1:0]    m_ad,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_din,
  output logic [N_MASTERS-1:0]             m_rvalid,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             sp_ce,
  output logic                             sp_oce,
  output logic                             sp_wre,
  output logic [AD_WIDTH-1:0]              sp_ad,
  output logic [DATA_WIDTH-1:0]            sp_din,
  input  logic [DATA_WIDTH-1:0]            sp_dout,
  output logic                             violation
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t                state, state_nxt;
  logic [N_MASTERS-1:0]  gnt, gnt_nxt;
  logic [IW-1:0]         owner, owner_nxt;
  logic [IW-1:0]         ptr, ptr_nxt;
  logic [HW-1:0]         hold_cnt, hold_nxt;
  logic [IW-1:0]         scan_id, win_id;
  logic                  win_found;
  logic                  others_req;
  logic                  release_owner;

  logic [AD_WIDTH-1:0]   ad_arr  [N_MASTERS];
  logic [DATA_WIDTH-1:0] din_arr [N_MASTERS];

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [IW-1:0]           pipe_id [READ_LATENCY];

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign ad_arr[g]  = m_ad[g*AD_WIDTH +: AD_WIDTH];
    assign din_arr[g] = m_din[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest rotation offset from ptr wins, so the scan runs from the far end down.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    if (MODE == 0) begin
      win_found = (int'(sel) < N_MASTERS) && m_req[sel];
      win_id    = sel;
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        scan_id = IW'((int'(ptr) + k) % N_MASTERS);
        if (m_req[scan_id]) begin
          win_found = 1'b1;
          win_id    = scan_id;
        end
      end
    end
  end

  assign others_req    = |(m_req & ~gnt);
  assign release_owner = (state == S_OWNED) &&
                         (!m_req[owner] ||
                          ((MAX_HOLD > 0) && (hold_cnt == '0) && others_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt = S_OWNED;
          owner_nxt = win_id;
          gnt_nxt   = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_id;
          hold_nxt  = HOLD_LOAD;
        end
      end
      S_OWNED: begin
        if (release_owner) begin
          state_nxt = S_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = (owner == IW'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
        end else if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sp_ce  = 1'b0;
    sp_wre = 1'b0;
    sp_ad  = '0;
    sp_din = '0;
    if (state == S_OWNED) begin
      sp_ce  = m_ce[owner];
      sp_wre = m_wre[owner];
      sp_ad  = ad_arr[owner];
      sp_din = din_arr[owner];
    end
  end

  assign m_gnt = gnt;

  // Read tags travel with the data latency so a regrant cannot steal an in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0] <= sp_ce & ~sp_wre;
      pipe_id[0]  <= owner;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  always_comb begin
    m_rvalid = '0;
    if (pipe_vld[READ_LATENCY-1]) m_rvalid[pipe_id[READ_LATENCY-1]] = 1'b1;
  end

  assign m_rdata = sp_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_oce    <= 1'b0;
      violation <= 1'b0;
    end else begin
      sp_oce    <= 1'b1;
      violation <= violation | (|(m_ce & ~gnt));
    end
  end

endmodule

// File: tb/tb_sp_port_arbiter.sv
// Directed bench for sp_port_arbiter: three instances (RR/LAT1/hold 8, RR/LAT2, fixed/LAT1)
// share one stimulus set; each scenario checks only the instance it targets.
module tb_sp_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [2:0]  m_req, m_ce, m_wre;
  logic [32:0] m_ad;
  logic [95:0] m_din;

  logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b, gnt_c, rvalid_c;
  logic [31:0] rdata_a, rdata_b, rdata_c, din_a, din_b, din_c;
  logic [31:0] dout_a, dout_c, d1_b, d2_b;
  logic [10:0] ad_a, ad_b, ad_c;
  logic        ce_a, oce_a, wre_a, viol_a;
  logic        ce_b, oce_b, wre_b, viol_b;
  logic        ce_c, oce_c, wre_c, viol_c;
  logic [31:0] mem_a [2048];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_port_arbiter #(.N_MASTERS(3), .AD_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(1),
                    .MODE(1), .MAX_HOLD(8)) u_a (
    .clk(clk), .rst(rst), .sel(sel), .m_req(m_req), .m_gnt(gnt_a), .m_ce(m_ce), .m_wre(m_wre),
    .m_ad(m_ad), .m_din(m_din), .m_rvalid(rvalid_a), .m_rdata(rdata_a), .sp_ce(ce_a),
    .sp_oce(oce_a), .sp_wre(wre_a), .sp_ad(ad_a), .sp_din(din_a), .sp_dout(dout_a),
    .violation(viol_a));

  sp_port_arbiter #(.N_MASTERS(3), .AD_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(2),
                    .MODE(1), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .sel(sel), .m_req(m_req), .m_gnt(gnt_b), .m_ce(m_ce), .m_wre(m_wre),
    .m_ad(m_ad), .m_din(m_din), .m_rvalid(rvalid_b), .m_rdata(rdata_b), .sp_ce(ce_b),
    .sp_oce(oce_b), .sp_wre(wre_b), .sp_ad(ad_b), .sp_din(din_b), .sp_dout(d2_b),
    .violation(viol_b));

  sp_port_arbiter #(.N_MASTERS(3), .AD_WIDTH(11), .DATA_WIDTH(32), .READ_LATENCY(1),
                    .MODE(0), .MAX_HOLD(0)) u_c (
    .clk(clk), .rst(rst), .sel(sel), .m_req(m_req), .m_gnt(gnt_c), .m_ce(m_ce), .m_wre(m_wre),
    .m_ad(m_ad), .m_din(m_din), .m_rvalid(rvalid_c), .m_rdata(rdata_c), .sp_ce(ce_c),
    .sp_oce(oce_c), .sp_wre(wre_c), .sp_ad(ad_c), .sp_din(din_c), .sp_dout(dout_c),
    .violation(viol_c));

  // BSRAM models: A is a real RAM with 1-cycle read, B is a 2-stage pipelined ROM f(ad)
  always @(posedge clk) begin
    if (ce_a) begin
      if (wre_a) mem_a[ad_a] <= din_a;
      else       dout_a      <= mem_a[ad_a];
    end
    if (ce_b && !wre_b) d1_b <= 32'hC0DE_0000 | {21'd0, ad_b};
    d2_b <= d1_b;
  end
  assign dout_c = 32'd0;

  function automatic logic [31:0] rom_b(input logic [10:0] a);
    return 32'hC0DE_0000 | {21'd0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel   = 2'd0;
    m_req = 3'b000;
    m_ce  = 3'b000;
    m_wre = 3'b000;
    m_ad  = {11'h102, 11'h101, 11'h100};
    m_din = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
  endtask

  // Leaves the bench at posedge+1 of cycle 0, the first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  ce;
    logic [2:0]  wre;
    logic [2:0]  gnt;
    logic        spce;
    logic [10:0] spad;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000};
    vecs[1]  = '{3'b111, 3'b001, 3'b001, 3'b001, 1'b1, 11'h100};
    vecs[2]  = '{3'b111, 3'b001, 3'b000, 3'b001, 1'b1, 11'h100};
    vecs[3]  = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 11'h100};
    vecs[4]  = '{3'b110, 3'b001, 3'b000, 3'b001, 1'b1, 11'h100};
    vecs[5]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000};
    vecs[6]  = '{3'b111, 3'b010, 3'b000, 3'b010, 1'b1, 11'h101};
    vecs[7]  = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b0, 11'h101};
    vecs[8]  = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b0, 11'h101};
    vecs[9]  = '{3'b101, 3'b000, 3'b000, 3'b010, 1'b0, 11'h101};
    vecs[10] = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000};
    vecs[11] = '{3'b111, 3'b100, 3'b100, 3'b100, 1'b1, 11'h102};
    vecs[12] = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b0, 11'h102};
    vecs[13] = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b0, 11'h102};
    vecs[14] = '{3'b011, 3'b000, 3'b000, 3'b100, 1'b0, 11'h102};
    vecs[15] = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 11'h000};
    vecs[16] = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 11'h100};

    // reset state
    rst = 1'b1;
    idle_inputs();
    m_req = 3'b111;
    m_ce  = 3'b111;
    repeat (2) step();
    #2;
    chk("rst_gnt",    {29'd0, gnt_a},    32'd0);
    chk("rst_rvalid", {29'd0, rvalid_a}, 32'd0);
    chk("rst_sp_ce",  {31'd0, ce_a},     32'd0);
    chk("rst_sp_oce", {31'd0, oce_a},    32'd0);
    chk("rst_sp_ad",  {21'd0, ad_a},     32'd0);
    chk("rst_viol",   {31'd0, viol_a},   32'd0);

    // round robin, all requesting from reset exit, 4-cycle bursts
    do_reset();
    for (int i = 0; i < 17; i++) begin
      m_req = vecs[i].req;
      m_ce  = vecs[i].ce;
      m_wre = vecs[i].wre;
      #2;
      chk($sformatf("rr_gnt[%0d]", i),   {29'd0, gnt_a}, {29'd0, vecs[i].gnt});
      chk($sformatf("rr_sp_ce[%0d]", i), {31'd0, ce_a},  {31'd0, vecs[i].spce});
      chk($sformatf("rr_sp_ad[%0d]", i), {21'd0, ad_a},  {21'd0, vecs[i].spad});
      step();
    end
    chk("rr_sp_oce", {31'd0, oce_a},  32'd1);
    chk("rr_viol",   {31'd0, viol_a}, 32'd0);

    // master1 writes, releases while master2 requests; master2 reads back
    do_reset();
    m_ad[11 +: 11]  = 11'h155;
    m_ad[22 +: 11]  = 11'h155;
    m_din[32 +: 32] = 32'hDEAD_BEEF;
    m_req = 3'b010;
    step();
    m_req = 3'b100;
    m_ce  = 3'b010;
    m_wre = 3'b010;
    #2;
    chk("wr_gnt",    {29'd0, gnt_a}, 32'h2);
    chk("wr_sp_ce",  {31'd0, ce_a},  32'd1);
    chk("wr_sp_wre", {31'd0, wre_a}, 32'd1);
    chk("wr_sp_ad",  {21'd0, ad_a},  32'h155);
    chk("wr_sp_din", din_a,          32'hDEAD_BEEF);
    step();
    m_ce  = 3'b000;
    m_wre = 3'b000;
    #2;
    chk("wr_dead_gnt", {29'd0, gnt_a}, 32'd0);
    step();
    m_ce = 3'b100;
    #2;
    chk("rd_gnt",    {29'd0, gnt_a}, 32'h4);
    chk("rd_sp_wre", {31'd0, wre_a}, 32'd0);
    step();
    m_ce  = 3'b000;
    m_req = 3'b000;
    #2;
    chk("rd_rvalid", {29'd0, rvalid_a}, 32'h4);
    chk("rd_rdata",  rdata_a,           32'hDEAD_BEEF);
    step();
    #2;
    chk("rd_rvalid_end", {29'd0, rvalid_a}, 32'd0);
    chk("rd_viol",       {31'd0, viol_a},   32'd0);

    // latency 2: in-flight reads still return to master0 after master1 is granted
    do_reset();
    m_req = 3'b011;
    step();
    m_ce = 3'b001;
    m_ad[0 +: 11] = 11'h040;
    #2;
    chk("l2_gnt0", {29'd0, gnt_b}, 32'h1);
    step();
    m_ad[0 +: 11] = 11'h041;
    #2;
    chk("l2_rv_c2", {29'd0, rvalid_b}, 32'd0);
    step();
    m_ad[0 +: 11] = 11'h042;
    m_req = 3'b010;
    #2;
    chk("l2_rv_c3", {29'd0, rvalid_b}, 32'h1);
    chk("l2_rd_c3", rdata_b, rom_b(11'h040));
    step();
    m_ce = 3'b000;
    #2;
    chk("l2_gnt_c4", {29'd0, gnt_b},    32'd0);
    chk("l2_rv_c4",  {29'd0, rvalid_b}, 32'h1);
    chk("l2_rd_c4",  rdata_b, rom_b(11'h041));
    step();
    #2;
    chk("l2_gnt_c5", {29'd0, gnt_b},    32'h2);
    chk("l2_rv_c5",  {29'd0, rvalid_b}, 32'h1);
    chk("l2_rd_c5",  rdata_b, rom_b(11'h042));
    for (int i = 6; i < 8; i++) begin
      step();
      #2;
      chk($sformatf("l2_rv_c%0d", i), {29'd0, rvalid_b}, 32'd0);
    end

    // fixed mode: only sel may win, sel changes while owned are ignored
    do_reset();
    sel   = 2'd2;
    m_req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("fx_nogrant[%0d]", i), {29'd0, gnt_c}, 32'd0);
      step();
    end
    sel = 2'd1;
    step();
    sel = 2'd0;
    #2;
    chk("fx_gnt1", {29'd0, gnt_c}, 32'h2);
    step();
    #2;
    chk("fx_hold_c5", {29'd0, gnt_c}, 32'h2);
    step();
    m_req = 3'b001;
    #2;
    chk("fx_hold_c6", {29'd0, gnt_c}, 32'h2);
    step();
    #2;
    chk("fx_idle_c7", {29'd0, gnt_c}, 32'd0);
    step();
    #2;
    chk("fx_gnt0_c8", {29'd0, gnt_c}, 32'h1);

    // hold limit 8 with a competing request from cycle 2
    do_reset();
    m_req = 3'b001;
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) m_req = 3'b011;
      #2;
      chk($sformatf("mh_gnt_c%0d", c), {29'd0, gnt_a}, 32'h1);
      step();
    end
    m_ce = 3'b001;
    #2;
    chk("mh_rel_gnt",  {29'd0, gnt_a}, 32'd0);
    chk("mh_rel_ce",   {31'd0, ce_a},  32'd0);
    chk("mh_viol_pre", {31'd0, viol_a}, 32'd0);
    step();
    m_ce = 3'b000;
    #2;
    chk("mh_next_gnt", {29'd0, gnt_a},  32'h2);
    chk("mh_viol",     {31'd0, viol_a}, 32'd1);

    // hold counter saturates with no competitor, releases at once when one appears
    do_reset();
    m_req = 3'b001;
    repeat (13) step();
    #2;
    chk("sat_gnt_c13", {29'd0, gnt_a}, 32'h1);
    m_req = 3'b011;
    #1;
    chk("sat_gnt_c13b", {29'd0, gnt_a}, 32'h1);
    step();
    #2;
    chk("sat_rel_c14", {29'd0, gnt_a}, 32'd0);

    // reset mid-burst with reads in flight
    do_reset();
    m_req = 3'b001;
    step();
    m_ce = 3'b001;
    m_ad[0 +: 11] = 11'h040;
    #2;
    chk("mr_gnt", {29'd0, gnt_b}, 32'h1);
    step();
    rst = 1'b1;
    #2;
    chk("mr_gnt_a",   {29'd0, gnt_a},    32'd0);
    chk("mr_gnt_b",   {29'd0, gnt_b},    32'd0);
    chk("mr_sp_ce_a", {31'd0, ce_a},     32'd0);
    chk("mr_sp_ce_b", {31'd0, ce_b},     32'd0);
    chk("mr_rv_b",    {29'd0, rvalid_b}, 32'd0);
    step();
    #2;
    chk("mr_sp_ce_a2", {31'd0, ce_a}, 32'd0);
    step();
    rst   = 1'b0;
    m_ce  = 3'b000;
    m_req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("mr_rv_a[%0d]", i), {29'd0, rvalid_a}, 32'd0);
      chk($sformatf("mr_rv_b[%0d]", i), {29'd0, rvalid_b}, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
